// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM mode sequencer
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_e;
  localparam int MODE_W = 4;
  localparam logic [MODE_W-1:0] MODE_OFF = 4'd0;
  localparam int STEP_DWELL_W = 8;
  typedef struct packed {
    logic [MODE_W-1:0]       mode;
    logic [STEP_DWELL_W-1:0] dwell;
  } step_t;
endpackage

// File: rtl/pwm_seq_table.sv
// pwm_seq_table: step table register file, one sync write port and one comb read port
module pwm_seq_table
  import pwm_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [MODE_W+DWELL_W-1:0] wdata,
  input  logic [IDX_W-1:0]          raddr,
  output logic [MODE_W+DWELL_W-1:0] rdata
);
  logic [MODE_W+DWELL_W-1:0] mem_q [2**IDX_W];
  logic [MODE_W+DWELL_W-1:0] mem_d [2**IDX_W];
  // next table contents: only the addressed entry changes on a write
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  // table storage, deliberately not reset
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pwm_mode_sequencer.sv
// pwm_mode_sequencer: replays (mode, dwell) steps to a PWM generator on period boundaries
module pwm_mode_sequencer
  import pwm_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [MODE_W-1:0]  wr_mode,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [IDX_W:0]     len,
  input  logic               loop,
  input  logic               start,
  input  logic               abort,
  input  logic               period_wrap,
  output logic [MODE_W-1:0]  mode,
  output logic               pwm_rst,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   cur_idx,
  output logic               err
);
  localparam logic [IDX_W:0]     DEPTH = (IDX_W+1)'(2**IDX_W);
  localparam logic [DWELL_W-1:0] ONE   = DWELL_W'(1);
  state_e             state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               pwm_rst_q, pwm_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W:0]     len_q, len_d;
  logic               loop_q, loop_d;
  logic [IDX_W-1:0]   rd_addr, nxt_idx;
  logic [MODE_W+DWELL_W-1:0] rd_data;
  logic [MODE_W-1:0]  rd_mode;
  logic [DWELL_W-1:0] rd_dwell, load_cnt;
  logic               len_ok, last, step_end, idle;
  assign idle     = state_q == IDLE;
  assign len_ok   = len != '0 && len <= DEPTH;
  assign last     = {1'b0, idx_q} == len_q - 1'b1;
  assign step_end = period_wrap && cnt_q == ONE;
  assign nxt_idx  = last ? '0 : idx_q + 1'b1;
  assign rd_addr  = state_q == RUN ? nxt_idx : '0;
  assign rd_mode  = rd_data[DWELL_W +: MODE_W];
  assign rd_dwell = rd_data[DWELL_W-1:0];
  assign load_cnt = rd_dwell == '0 ? ONE : rd_dwell;
  pwm_seq_table #(.IDX_W(IDX_W), .DWELL_W(DWELL_W)) u_table (
    .clk  (clk),
    .we   (wr_en && idle),
    .waddr(wr_addr),
    .wdata({wr_mode, wr_dwell}),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_OFF;
      pwm_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pwm_rst_q <= pwm_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
    end
  end
  // next state: abort beats a simultaneous period_wrap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start && len_ok ? ARM : IDLE;
      ARM:     state_d = abort ? STOP : RUN;
      RUN:     state_d = abort || (step_end && last && !loop_q) ? STOP : RUN;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs, step index and dwell counter
  always_comb begin
    mode_d    = mode_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    loop_d    = loop_q;
    done_d    = state_d == STOP;
    pwm_rst_d = state_d != RUN;
    err_d     = idle ? start && !len_ok : start || wr_en;
    if (idle && state_d == ARM) begin
      mode_d = wr_en && wr_addr == '0 ? wr_mode : rd_mode;
      idx_d  = '0;
      len_d  = len;
      loop_d = loop;
    end
    if (state_q == ARM && state_d == RUN) begin
      mode_d = rd_mode;
      cnt_d  = load_cnt;
    end
    if (state_q == RUN && state_d == RUN && period_wrap) begin
      mode_d = step_end ? rd_mode : mode_q;
      idx_d  = step_end ? nxt_idx : idx_q;
      cnt_d  = step_end ? load_cnt : cnt_q - 1'b1;
    end
    if (state_d == STOP) begin
      mode_d = MODE_OFF;
      cnt_d  = '0;
    end
  end
  assign mode    = mode_q;
  assign pwm_rst = pwm_rst_q;
  assign busy    = !idle;
  assign done    = done_q;
  assign cur_idx = idx_q;
  assign err     = err_q;
endmodule

// File: tb/tb_pwm_mode_sequencer.sv
// tb_pwm_mode_sequencer: scoreboard bench comparing every output change against queued expectations
module tb_pwm_mode_sequencer;
  import pwm_pkg::*;
  logic clk = 0, rst = 1;
  logic wr_en = 0, loop = 0, start = 0, abort = 0, period_wrap = 0;
  logic [2:0] wr_addr = 0;
  logic [3:0] wr_mode = 0;
  logic [7:0] wr_dwell = 0;
  logic [3:0] len = 0;
  logic [3:0] mode;
  logic pwm_rst, busy, done, err;
  logic [2:0] cur_idx;
  int checks = 0, errors = 0;
  logic [11:0] qv[$];
  string qn[$];
  logic [11:0] cur, prev, want;
  string nm;
  bit first = 1, mon_en = 0;

  pwm_mode_sequencer #(.IDX_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_dwell(wr_dwell), .len(len), .loop(loop), .start(start), .abort(abort),
    .period_wrap(period_wrap), .mode(mode), .pwm_rst(pwm_rst), .busy(busy),
    .done(done), .cur_idx(cur_idx), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] o(int m, int r, int b, int d, int e, int i);
    return {4'(m), 1'(r), 1'(b), 1'(d), 1'(e), 3'(i)};
  endfunction

  task automatic expect_obs(input logic [11:0] v, input string n);
    qv.push_back(v);
    qn.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wrap();
    period_wrap = 1;
    tick();
    period_wrap = 0;
    tick();
  endtask

  task automatic wr(input int a, input int m, input int d);
    wr_en = 1; wr_addr = 3'(a); wr_mode = 4'(m); wr_dwell = 8'(d);
    tick();
    wr_en = 0;
  endtask

  // monitor: every change of the output tuple {mode,pwm_rst,busy,done,err,cur_idx} pops one expectation
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {mode, pwm_rst, busy, done, err, cur_idx};
      if (first || cur !== prev) begin
        checks++;
        if (qv.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got %h want no change (prev %h) t=%0t", cur, prev, $time);
        end else begin
          want = qv.pop_front();
          nm = qn.pop_front();
          if (cur !== want) begin
            errors++;
            $display("FAIL %s got %h want %h t=%0t", nm, cur, want, $time);
          end
        end
      end
      first = 0;
      prev = cur;
    end
  end

  initial begin
    tick(); tick();
    expect_obs(o(0,1,0,0,0,0), "reset_state");
    mon_en = 1;
    rst = 0;
    tick();
    wrap(); wrap(); wrap();
    abort = 1; tick(); abort = 0; tick();
    // two-step sequence, no loop
    wr(0, 2, 3);
    wr(1, 3, 1);
    len = 2; loop = 0; start = 1;
    expect_obs(o(2,1,1,0,0,0), "two_arm");
    tick(); start = 0;
    expect_obs(o(2,0,1,0,0,0), "two_run");
    tick();
    wrap(); wrap();
    expect_obs(o(3,0,1,0,0,1), "two_step1");
    wrap();
    expect_obs(o(0,1,1,1,0,1), "two_stop");
    expect_obs(o(0,1,0,0,0,1), "two_idle");
    wrap(); tick();
    // rejected starts: len 0 and len above depth
    len = 0; start = 1;
    expect_obs(o(0,1,0,0,1,1), "len0_err");
    expect_obs(o(0,1,0,0,0,1), "len0_err_end");
    tick(); start = 0; tick();
    len = 9; start = 1;
    expect_obs(o(0,1,0,0,1,1), "len9_err");
    expect_obs(o(0,1,0,0,0,1), "len9_err_end");
    tick(); start = 0; tick();
    // loop with zero dwell
    wr(0, 1, 0);
    len = 1; loop = 1; start = 1;
    expect_obs(o(1,1,1,0,0,0), "loop_arm");
    tick(); start = 0;
    expect_obs(o(1,0,1,0,0,0), "loop_run");
    tick();
    wrap(); wrap();
    expect_obs(o(1,0,1,0,1,0), "busy_wr_err");
    expect_obs(o(1,0,1,0,0,0), "busy_wr_err_end");
    wr(0, 4, 5); tick();
    expect_obs(o(1,0,1,0,1,0), "busy_start_err");
    expect_obs(o(1,0,1,0,0,0), "busy_start_err_end");
    start = 1; tick(); start = 0; tick();
    expect_obs(o(0,1,1,1,0,0), "abort_wrap_stop");
    expect_obs(o(0,1,0,0,0,0), "abort_wrap_idle");
    abort = 1; period_wrap = 1; tick(); abort = 0; period_wrap = 0;
    tick(); tick();
    // readback: entry 0 must still be {1,0}, dwell 0 ends after one wrap
    len = 1; loop = 0; start = 1;
    expect_obs(o(1,1,1,0,0,0), "readback_arm");
    tick(); start = 0;
    expect_obs(o(1,0,1,0,0,0), "readback_run");
    tick();
    expect_obs(o(0,1,1,1,0,0), "readback_stop");
    expect_obs(o(0,1,0,0,0,0), "readback_idle");
    wrap(); tick();
    // same-cycle write and start
    wr_en = 1; wr_addr = 0; wr_mode = 4; wr_dwell = 2;
    len = 1; start = 1;
    expect_obs(o(4,1,1,0,0,0), "wrstart_arm");
    tick(); wr_en = 0; start = 0;
    expect_obs(o(4,0,1,0,0,0), "wrstart_run");
    tick();
    wrap();
    expect_obs(o(0,1,1,1,0,0), "wrstart_stop");
    expect_obs(o(0,1,0,0,0,0), "wrstart_idle");
    wrap(); tick();
    // abort during ARM
    start = 1;
    expect_obs(o(4,1,1,0,0,0), "armabort_arm");
    tick(); start = 0; abort = 1;
    expect_obs(o(0,1,1,1,0,0), "armabort_stop");
    expect_obs(o(0,1,0,0,0,0), "armabort_idle");
    tick(); abort = 0; tick(); tick();
    // reset mid-run at step 1
    len = 2; start = 1;
    expect_obs(o(4,1,1,0,0,0), "rstrun_arm");
    tick(); start = 0;
    expect_obs(o(4,0,1,0,0,0), "rstrun_run");
    tick();
    wrap();
    expect_obs(o(3,0,1,0,0,1), "rstrun_step1");
    wrap();
    rst = 1;
    expect_obs(o(0,1,0,0,0,0), "rstrun_reset");
    tick(); rst = 0;
    tick(); tick(); tick();
    checks++;
    if (qv.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d want 0 (next %s)", qv.size(), qn[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
